// File: rtl/mcontrol_pkg.sv
// mcontrol_pkg
// Shared definitions for the multi-channel memory-control front end:
// the FSM state type, the bus width codes driven on width_out, and the
// default values for the top-level parameters.
// No ports (package).

package mcontrol_pkg;

  typedef enum logic {
    MC_IDLE   = 1'b0,
    MC_ACTIVE = 1'b1
  } mc_state_e;

  // Bus width codes carried on width_out.
  localparam logic [3:0] W_BYTE   = 4'b0000;
  localparam logic [3:0] W_WORD   = 4'b0001;
  localparam logic [3:0] W_LONG   = 4'b0010;
  localparam logic [3:0] W_PHRASE = 4'b1000;

  localparam int DEF_AW       = 24;
  localparam int DEF_NCH      = 2;
  localparam int DEF_RQ_DEPTH = 2;

endpackage

// File: rtl/mc_tagq.sv
// mc_tagq
// Small FIFO of channel ids, one entry per read whose address phase has
// completed but whose data has not yet come back.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   push, pushId    enqueue an id
//   pop             dequeue the head entry
//   headId          id at the head of the queue
//   full, empty     occupancy flags
//   count           occupancy, 0..DEPTH

module mc_tagq
  import mcontrol_pkg::*;
#(
  parameter int DEPTH = DEF_RQ_DEPTH,
  parameter int IDW   = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [IDW-1:0]         pushId,
  input  logic                   pop,
  output logic [IDW-1:0]         headId,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [IDW-1:0] mem_q [DEPTH];
  logic [PW-1:0]  wrPtr_q;
  logic [PW-1:0]  rdPtr_q;
  logic [PW:0]    count_q;
  logic           doPush;
  logic           doPop;

  // A push into a full queue is only honoured when a pop frees the slot
  // in the same cycle.
  assign doPop  = pop & ~empty;
  assign doPush = push & (~full | doPop);

  assign empty  = (count_q == '0);
  assign full   = (count_q == (PW+1)'(DEPTH));
  assign count  = count_q;
  assign headId = mem_q[rdPtr_q];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
      if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
      count_q <= count_q + {{PW{1'b0}}, doPush} - {{PW{1'b0}}, doPop};
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushId;
  end

endmodule

// File: rtl/mcontrol_mch.sv
// mcontrol_mch
// Multi-channel memory-control front end. Round-robin arbitrates NCH
// requesters onto the shared memory bus, holds the winning cycle in a
// register while it is on the bus, and steers each read-data acknowledge
// back to the channel that issued the read.
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   req_valid/write/addr/width/justify  per-channel request fields
//   req_ready                        one-hot accept (combinational)
//   bus_grant, ack, dack             bus ownership, address ack, data ack
//   *_out / *_oe                     bus outputs and grant-gated enables
//   active, memidle, memready        cycle status
//   read_ack, dack_err               registered data-return pulses

module mcontrol_mch
  import mcontrol_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int NCH      = DEF_NCH,
  parameter int RQ_DEPTH = DEF_RQ_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NCH-1:0]    req_valid,
  input  logic [NCH-1:0]    req_write,
  input  logic [NCH*AW-1:0] req_addr,
  input  logic [NCH*4-1:0]  req_width,
  input  logic [NCH-1:0]    req_justify,
  output logic [NCH-1:0]    req_ready,
  input  logic              bus_grant,
  input  logic              ack,
  input  logic              dack,
  output logic [AW-1:0]     blit_addr_out,
  output logic              blit_addr_oe,
  output logic              mreq_out,
  output logic              mreq_oe,
  output logic              read_out,
  output logic              read_oe,
  output logic [3:0]        width_out,
  output logic              width_oe,
  output logic              justify_out,
  output logic              justify_oe,
  output logic              active,
  output logic              memready,
  output logic              memidle,
  output logic [NCH-1:0]    read_ack,
  output logic              dack_err
);

  localparam int CW  = $clog2(NCH);
  localparam int QCW = $clog2(RQ_DEPTH) + 1;

  mc_state_e      state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic           read_q, read_d;
  logic [3:0]     width_q, width_d;
  logic           justify_q, justify_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [CW-1:0]  lastGrant_q, lastGrant_d;
  logic [NCH-1:0] readAck_q, readAck_d;
  logic           dackErr_q, dackErr_d;

  logic           complete;
  logic           arbOpen;
  logic           accept;
  logic [QCW-1:0] rdCredit;
  logic           creditOk;
  logic [NCH-1:0] eligible;
  logic           winValid;
  logic [CW-1:0]  winIdx;
  logic [CW:0]    cand;

  logic           qPush;
  logic           qPop;
  logic [CW-1:0]  qHead;
  logic           qFull;
  logic           qEmpty;
  logic [QCW-1:0] qCount;

  assign complete = (state_q == MC_ACTIVE) & ack & bus_grant;
  assign arbOpen  = (state_q == MC_IDLE) | complete;

  // The read currently on the bus already owns a queue slot, so it counts
  // against the credit before it is pushed.
  assign rdCredit = qCount + {{(QCW-1){1'b0}}, (state_q == MC_ACTIVE) & read_q};
  assign creditOk = (rdCredit < QCW'(RQ_DEPTH));
  assign eligible = req_valid & (req_write | {NCH{creditOk}});

  // Round-robin search from lastGrant+1. Scanning from the farthest
  // candidate down lets the nearest eligible one overwrite the others.
  always_comb begin
    winValid = 1'b0;
    winIdx   = '0;
    cand     = '0;
    for (int k = NCH; k >= 1; k--) begin
      cand = {1'b0, lastGrant_q} + (CW+1)'(k);
      if (cand >= (CW+1)'(NCH)) cand = cand - (CW+1)'(NCH);
      if (eligible[cand[CW-1:0]]) begin
        winValid = 1'b1;
        winIdx   = cand[CW-1:0];
      end
    end
  end

  assign accept    = arbOpen & winValid;
  assign req_ready = accept ? (NCH'(1) << winIdx) : '0;

  // Next-state: a new accept reloads the cycle register (so completion
  // plus accept keeps the bus busy with no bubble); otherwise completion
  // returns to idle. Data-return pulses are decided one cycle early.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    read_d      = read_q;
    width_d     = width_q;
    justify_d   = justify_q;
    ch_d        = ch_q;
    lastGrant_d = lastGrant_q;
    readAck_d   = '0;
    dackErr_d   = 1'b0;
    if (accept) begin
      state_d     = MC_ACTIVE;
      addr_d      = req_addr[winIdx*AW +: AW];
      read_d      = ~req_write[winIdx];
      width_d     = req_width[winIdx*4 +: 4];
      justify_d   = req_justify[winIdx];
      ch_d        = winIdx;
      lastGrant_d = winIdx;
    end else if (complete) begin
      state_d = MC_IDLE;
    end
    if (dack) begin
      if (qEmpty) dackErr_d = 1'b1;
      else        readAck_d = NCH'(1) << qHead;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= MC_IDLE;
      addr_q      <= '0;
      read_q      <= 1'b0;
      width_q     <= '0;
      justify_q   <= 1'b0;
      ch_q        <= '0;
      lastGrant_q <= CW'(NCH - 1);
      readAck_q   <= '0;
      dackErr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      read_q      <= read_d;
      width_q     <= width_d;
      justify_q   <= justify_d;
      ch_q        <= ch_d;
      lastGrant_q <= lastGrant_d;
      readAck_q   <= readAck_d;
      dackErr_q   <= dackErr_d;
    end
  end

  assign qPush = complete & read_q & (~qFull | qPop);
  assign qPop  = dack & ~qEmpty;

  mc_tagq #(
    .DEPTH (RQ_DEPTH),
    .IDW   (CW)
  ) u_tagq (
    .clk    (clk),
    .reset  (reset),
    .push   (qPush),
    .pushId (ch_q),
    .pop    (qPop),
    .headId (qHead),
    .full   (qFull),
    .empty  (qEmpty),
    .count  (qCount)
  );

  assign active        = (state_q == MC_ACTIVE);
  assign memidle       = ~active;
  assign memready      = complete;
  assign mreq_out      = active;
  assign read_out      = read_q;
  assign width_out     = width_q;
  assign justify_out   = justify_q;
  assign blit_addr_out = addr_q;
  assign read_ack      = readAck_q;
  assign dack_err      = dackErr_q;

  assign blit_addr_oe  = bus_grant;
  assign mreq_oe       = bus_grant;
  assign read_oe       = bus_grant;
  assign width_oe      = bus_grant;
  assign justify_oe    = bus_grant;

endmodule

// File: tb/tb_mcontrol_mch.sv
// tb_mcontrol_mch
// Directed scenarios followed by randomized traffic, every cycle compared
// against a transaction-level model (busy flag, current cycle record and a
// queue of outstanding read channel ids).

module tb_mcontrol_mch;
  import mcontrol_pkg::*;

  localparam int AW       = 24;
  localparam int NCH      = 2;
  localparam int RQ_DEPTH = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [NCH-1:0]    req_valid, req_write, req_justify, req_ready, read_ack;
  logic [NCH*AW-1:0] req_addr;
  logic [NCH*4-1:0]  req_width;
  logic              bus_grant, ack, dack;
  logic [AW-1:0]     blit_addr_out;
  logic              blit_addr_oe, mreq_out, mreq_oe, read_out, read_oe;
  logic [3:0]        width_out;
  logic              width_oe, justify_out, justify_oe;
  logic              active, memready, memidle, dack_err;

  always #5 clk = ~clk;

  mcontrol_mch #(.AW(AW), .NCH(NCH), .RQ_DEPTH(RQ_DEPTH)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_width(req_width), .req_justify(req_justify), .req_ready(req_ready),
    .bus_grant(bus_grant), .ack(ack), .dack(dack),
    .blit_addr_out(blit_addr_out), .blit_addr_oe(blit_addr_oe),
    .mreq_out(mreq_out), .mreq_oe(mreq_oe),
    .read_out(read_out), .read_oe(read_oe),
    .width_out(width_out), .width_oe(width_oe),
    .justify_out(justify_out), .justify_oe(justify_oe),
    .active(active), .memready(memready), .memidle(memidle),
    .read_ack(read_ack), .dack_err(dack_err)
  );

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model of the front end.
  logic           modelValid = 1'b0;
  logic           mBusy = 1'b0;
  logic [AW-1:0]  mAddr = '0;
  logic           mRead = 1'b0;
  logic [3:0]     mWidth = '0;
  logic           mJust = 1'b0;
  int             mCh = 0;
  int             mLast = NCH - 1;
  int             mQ[$];
  logic [NCH-1:0] mReadAck = '0;
  logic           mDackErr = 1'b0;

  int             predWin;
  logic [NCH-1:0] predReady;
  logic           predMemready;

  // Snapshot of DUT outputs taken mid-cycle.
  logic [NCH-1:0] sReady, sReadAck;
  logic           sMemready, sActive, sMemidle, sMreq, sRead, sJust, sDackErr;
  logic [AW-1:0]  sAddr;
  logic [3:0]     sWidth;
  logic [4:0]     sOe;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nVectors++;
    if (act !== exp) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic setQuiet();
    reset       = 1'b0;
    req_valid   = '0;
    req_write   = '0;
    req_addr    = '0;
    req_width   = '0;
    req_justify = '0;
    bus_grant   = 1'b1;
    ack         = 1'b0;
    dack        = 1'b0;
  endtask

  task automatic modelPredict();
    int credit;
    int idx;
    predMemready = mBusy && ack && bus_grant;
    credit = mQ.size() + ((mBusy && mRead) ? 1 : 0);
    predWin = -1;
    if (!mBusy || predMemready) begin
      for (int k = 1; k <= NCH; k++) begin
        idx = (mLast + k) % NCH;
        if (predWin < 0 && req_valid[idx] && (req_write[idx] || credit < RQ_DEPTH))
          predWin = idx;
      end
    end
    predReady = (predWin >= 0) ? (NCH'(1) << predWin) : '0;
  endtask

  task automatic modelUpdate();
    if (dack) begin
      if (mQ.size() > 0) begin
        mReadAck = NCH'(1) << mQ.pop_front();
        mDackErr = 1'b0;
      end else begin
        mReadAck = '0;
        mDackErr = 1'b1;
      end
    end else begin
      mReadAck = '0;
      mDackErr = 1'b0;
    end
    if (predMemready && mRead) mQ.push_back(mCh);
    if (predWin >= 0) begin
      mBusy  = 1'b1;
      mAddr  = req_addr[predWin*AW +: AW];
      mRead  = !req_write[predWin];
      mWidth = req_width[predWin*4 +: 4];
      mJust  = req_justify[predWin];
      mCh    = predWin;
      mLast  = predWin;
    end else if (predMemready) begin
      mBusy = 1'b0;
    end
    if (reset) begin
      mBusy = 1'b0; mAddr = '0; mRead = 1'b0; mWidth = '0; mJust = 1'b0;
      mCh = 0; mLast = NCH - 1; mQ.delete();
      mReadAck = '0; mDackErr = 1'b0;
      modelValid = 1'b1;
    end
  endtask

  task automatic checkRegistered();
    checkOutput("active",   sActive,   mBusy);
    checkOutput("memidle",  sMemidle,  !mBusy);
    checkOutput("mreq",     sMreq,     mBusy);
    checkOutput("read_out", sRead,     mRead);
    checkOutput("addr",     sAddr,     mAddr);
    checkOutput("width",    sWidth,    mWidth);
    checkOutput("justify",  sJust,     mJust);
    checkOutput("read_ack", sReadAck,  mReadAck);
    checkOutput("dack_err", sDackErr,  mDackErr);
  endtask

  task automatic checkComb();
    checkOutput("req_ready", sReady,    predReady);
    checkOutput("memready",  sMemready, predMemready);
    checkOutput("oe",        sOe,       {5{bus_grant}});
  endtask

  // One clock cycle: inputs set by the caller apply to the cycle that
  // started at the last rising edge; outputs are sampled mid-cycle.
  task automatic applyStimulus();
    @(negedge clk);
    #1;
    sReady = req_ready; sReadAck = read_ack; sMemready = memready;
    sActive = active; sMemidle = memidle; sMreq = mreq_out; sRead = read_out;
    sJust = justify_out; sDackErr = dack_err; sAddr = blit_addr_out; sWidth = width_out;
    sOe = {blit_addr_oe, mreq_oe, read_oe, width_oe, justify_oe};
    modelPredict();
    if (modelValid) begin
      checkRegistered();
      checkComb();
    end
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    setQuiet();
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
  endtask

  initial begin
    // Reset values.
    doReset();
    applyStimulus();
    checkOutput("rst_active",   sActive,   0);
    checkOutput("rst_memidle",  sMemidle,  1);
    checkOutput("rst_mreq",     sMreq,     0);
    checkOutput("rst_read",     sRead,     0);
    checkOutput("rst_addr",     sAddr,     0);
    checkOutput("rst_read_ack", sReadAck,  0);
    checkOutput("rst_dack_err", sDackErr,  0);

    // Single write from ch0.
    req_valid = 2'b01; req_write = 2'b01;
    req_addr[0 +: AW] = 24'h123456; req_width[3:0] = W_PHRASE;
    applyStimulus();
    checkOutput("w_ready", sReady, 2'b01);
    setQuiet();
    applyStimulus();
    checkOutput("w_mreq",  sMreq,  1);
    checkOutput("w_read",  sRead,  0);
    checkOutput("w_addr",  sAddr,  24'h123456);
    checkOutput("w_width", sWidth, 4'b1000);
    applyStimulus();
    ack = 1'b1;
    applyStimulus();
    checkOutput("w_memready", sMemready, 1);
    ack = 1'b0;
    applyStimulus();
    checkOutput("w_done", sActive, 0);

    // Both channels writing continuously: grants alternate.
    doReset();
    req_valid = 2'b11; req_write = 2'b11;
    req_addr = {24'h0000B1, 24'h0000A0};
    applyStimulus();
    checkOutput("rr_g0", sReady, 2'b01);
    ack = 1'b1;
    for (int g = 1; g <= 3; g++) begin
      applyStimulus();
      checkOutput("rr_grant", sReady, (g % 2 == 1) ? 2'b10 : 2'b01);
      checkOutput("rr_mreq",  sMreq,  1);
    end
    checkOutput("rr_addr", sAddr, 24'h0000A0);
    req_valid = '0;
    applyStimulus();
    ack = 1'b0;
    applyStimulus();
    checkOutput("rr_idle", sActive, 0);

    // Read credit limit: third read from ch1 held off until a dack.
    doReset();
    req_valid = 2'b10; req_write = '0; ack = 1'b1;
    applyStimulus();
    checkOutput("cr_rd0", sReady, 2'b10);
    applyStimulus();
    checkOutput("cr_rd1", sReady, 2'b10);
    applyStimulus();
    checkOutput("cr_block_a", sReady, 2'b00);
    dack = 1'b1;
    applyStimulus();
    checkOutput("cr_block_b", sReady, 2'b00);
    dack = 1'b0;
    applyStimulus();
    checkOutput("cr_read_ack", sReadAck, 2'b10);
    checkOutput("cr_third",    sReady,   2'b10);
    req_valid = '0;
    applyStimulus();
    ack = 1'b0; dack = 1'b1;
    applyStimulus();
    applyStimulus();
    dack = 1'b0;
    applyStimulus();
    checkOutput("cr_drain", sReadAck, 2'b10);

    // Reads from ch0 then ch1 return in order; extra dack is an error.
    doReset();
    req_valid = 2'b01; req_write = '0;
    applyStimulus();
    checkOutput("ord_r0", sReady, 2'b01);
    req_valid = 2'b10; ack = 1'b1;
    applyStimulus();
    checkOutput("ord_r1", sReady, 2'b10);
    req_valid = '0;
    applyStimulus();
    ack = 1'b0; dack = 1'b1;
    applyStimulus();
    applyStimulus();
    checkOutput("ord_ack0", sReadAck, 2'b01);
    applyStimulus();
    checkOutput("ord_ack1", sReadAck, 2'b10);
    dack = 1'b0;
    applyStimulus();
    checkOutput("ord_err",    sDackErr, 1);
    checkOutput("ord_noack",  sReadAck, 2'b00);

    // Bus grant withdrawn during an active cycle.
    doReset();
    req_valid = 2'b01; req_write = 2'b01;
    applyStimulus();
    req_valid = '0; bus_grant = 1'b0; ack = 1'b1;
    applyStimulus();
    checkOutput("ng_oe",       sOe,       5'b00000);
    checkOutput("ng_memready", sMemready, 0);
    ack = 1'b0;
    applyStimulus();
    checkOutput("ng_held", sActive, 1);
    bus_grant = 1'b1; ack = 1'b1;
    applyStimulus();
    checkOutput("ng_done", sMemready, 1);
    checkOutput("ng_oe_on", sOe, 5'b11111);
    ack = 1'b0;
    applyStimulus();
    checkOutput("ng_idle", sActive, 0);

    // Reset with two reads queued and a write on the bus.
    doReset();
    req_valid = 2'b01; req_write = '0;
    applyStimulus();
    req_valid = 2'b10; ack = 1'b1;
    applyStimulus();
    req_valid = 2'b01; req_write = 2'b01;
    applyStimulus();
    checkOutput("mr_write", sReady, 2'b01);
    req_valid = '0; ack = 1'b0; reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    applyStimulus();
    checkOutput("mr_memidle", sMemidle, 1);
    dack = 1'b1;
    applyStimulus();
    dack = 1'b0;
    applyStimulus();
    checkOutput("mr_err",    sDackErr, 1);
    checkOutput("mr_noack",  sReadAck, 2'b00);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      reset       = ($urandom_range(0, 99) == 0);
      req_valid   = NCH'($urandom);
      req_write   = NCH'($urandom);
      req_justify = NCH'($urandom);
      for (int i = 0; i < NCH; i++) begin
        req_addr[i*AW +: AW] = AW'($urandom);
        req_width[i*4 +: 4]  = 4'($urandom);
      end
      bus_grant = ($urandom_range(0, 9) != 0);
      ack       = ($urandom_range(0, 2) == 0);
      dack      = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
